// File: rtl/alu_cmd_queue_if.sv
// Command and result handshake bundle for alu_cmd_queue.
// slave: the queue side. master: the producer/consumer side.
interface alu_cmd_queue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: DEPTH-entry command FIFO feeding an external combinational
// ALU, with a single output result register and valid/ready on both sides.
// Optional macro ALU_CMD_QUEUE_OPCHK_EN: opcodes 110/111 pop normally but
// produce res_data=0, res_err=1. Without it res_err is tied to 0.
module alu_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_cmd_queue_if.slave           bus,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [2:0]               alu_op,
  input  logic [31:0]              alu_c,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          push, pop, not_empty;
  cmd_t          head;

  assign not_empty     = (count_q != '0);
  assign bus.cmd_ready = (count_q != CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  // The result register is the only sink; pop whenever it is free or draining.
  assign pop           = not_empty && (!res_valid_q || bus.res_ready);
  assign head          = mem_q[rd_ptr_q];

  // Head entry goes straight to the ALU; zeros while empty so no stale data leaks.
  assign alu_a  = not_empty ? head.a  : '0;
  assign alu_b  = not_empty ? head.b  : '0;
  assign alu_op = not_empty ? head.op : '0;

  assign count         = count_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

  // Storage array: no reset needed, occupancy/pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
  end

  // Occupancy next-state; push+pop cancels out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef ALU_CMD_QUEUE_OPCHK_EN
  logic res_err_q, res_err_d;
  assign bus.res_err = res_err_q;

  // Result register next-state with illegal-opcode screening.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    if (pop) begin
      res_valid_d = 1'b1;
      if (head.op[2:1] == 2'b11) begin
        res_data_d = '0;
        res_err_d  = 1'b1;
      end else begin
        res_data_d = alu_c;
        res_err_d  = 1'b0;
      end
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) res_err_q <= 1'b0;
    else       res_err_q <= res_err_d;
  end
`else
  assign bus.res_err = 1'b0;

  // Result register next-state: every opcode loads the ALU output.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (pop) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_c;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end
`endif

  // Pointers, occupancy and result register; reset wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  producer offers a command.
REQ-005 Port: cmd_ready  output  1  queue accepts a command this cycle.
REQ-006 Port: cmd_op  input  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra.
REQ-007 Port: cmd_a  input  32  operand A.
REQ-008 Port: cmd_b  input  32  operand B.
REQ-009 Port: alu_a  output  32  operand A to the external combinational ALU.
REQ-010 Port: alu_b  output  32  operand B to the external ALU.
REQ-011 Port: alu_op  output  3  opcode to the external ALU.
REQ-012 Port: alu_c  input  32  external ALU result, same-cycle combinational function of alu_a/alu_b/alu_op.
REQ-013 Port: res_valid  output  1  result register holds a result.
REQ-014 Port: res_ready  input  1  consumer takes the result this cycle.
REQ-015 Port: res_data  output  32  result value.
REQ-016 Port: res_err  output  1  illegal-opcode flag for res_data.
REQ-017 Port: count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 cmd_ready SHALL equal (count != DEPTH); no same-cycle bypass when full.
REQ-019 Push SHALL occur when cmd_valid && cmd_ready; {cmd_op, cmd_a, cmd_b} written at the write pointer.
REQ-020 alu_a/alu_b/alu_op SHALL present the FIFO head entry when count != 0, and all zeros when empty.
REQ-021 Pop SHALL occur when count != 0 && (!res_valid || res_ready); on pop the result register loads alu_c and res_valid is set.
REQ-022 When res_valid && res_ready and no pop, res_valid SHALL clear; res_data holds its last value.
REQ-023 Latency SHALL be: command accepted in cycle N into an empty queue -> res_valid high in cycle N+2.
REQ-024 Throughput SHALL be one command per cycle with res_ready held high.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-027 While res_valid && !res_ready, res_data/res_err SHALL be stable and no pop occurs.
REQ-028 Commands SHALL produce results in strict acceptance order.

Reset
REQ-029 On reset: count=0, pointers=0, res_valid=0, res_data=0, res_err=0; cmd_ready=1 the following cycle.
REQ-030 Reset mid-operation SHALL discard all queued commands and any pending result; reset overrides simultaneous push/pop.

Configuration
REQ-031 Macro ALU_CMD_QUEUE_OPCHK_EN: when defined, opcodes 110/111 SHALL pop normally but load res_data=0, res_err=1; legal opcodes load res_err=0.
REQ-032 Without ALU_CMD_QUEUE_OPCHK_EN, res_err SHALL be constant 0 and res_data SHALL load alu_c for every opcode.

Verification
REQ-033 Reset, then push op=000 A=5 B=7 in cycle N -> alu_op=000 in N+1, res_valid=1 res_data=12 in N+2.
REQ-034 res_ready=0, push 5 commands back-to-back -> 1 held in result register, 4 in FIFO, cmd_ready=0 at count=4, 6th command not accepted.
REQ-035 Stream sub 3-5, sra 0x80000000>>4, srl 0x80000000>>4 with res_ready=1 -> results 0xFFFFFFFE, 0xF8000000, 0x08000000 on consecutive cycles, in order.
REQ-036 Push 10 commands with res_ready toggling every cycle -> all 10 results in order, count wraps correctly, no loss or duplication.
REQ-037 Queue holding 3 commands, assert reset for 1 cycle -> count=0, res_valid=0, no further results.
REQ-038 With ALU_CMD_QUEUE_OPCHK_EN, push op=111 A=1 B=1 -> res_valid=1, res_data=0, res_err=1; without the macro, res_err=0 and res_data=alu_c.
